// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the receiver.
// No logic of its own; zero latency.
// No flow control; constants and helpers only.
package uart_pkg;

  // FSM state encoding shared by both ends of the link
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 9;  // data bits plus the parity bit

  // Even parity over data plus parity bit: 1 means the frame is inconsistent
  function automatic logic parity(input logic [FRAME_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial input, resets to idle (1).
// Latency: STAGES clocks from pin to output.
// No flow control; samples every clock.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw line through the synchronizer chain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data LSB first, even parity, stop; oversampled at mid-bit.
// Latency: outputs update 1 clock after the mid-stop-bit rx_tick.
// No flow control: data_out is overwritten by the next completed frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  uart_state_t           state;
  logic [TW-1:0]         tick_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  rx_s;
  // Set once the line has been seen idle in IDLE; a break must go high
  // again before a new start bit is accepted.
  logic                  armed;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Receive FSM with registered outputs, advancing only on rx_tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_tick) begin
        case (state)
          IDLE: begin
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == MID_START) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                // Start bit did not hold to its centre: treat as a glitch
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              shreg    <= {rx_s, shreg[FRAME_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              data_out   <= shreg[DATA_BITS-1:0];
              parity_err <= parity(shreg);
              frame_err  <= ~rx_s;
              rx_done    <= 1'b1;
              rx_busy    <= 1'b0;
              tick_cnt   <= '0;
              // Leaving at mid-stop catches a start bit with zero idle gap
              state      <= IDLE;
              armed      <= rx_s;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, random frames, corner sequences.
// Frames are driven 16 ticks per bit with rx_tick every 4 clocks.
// Received bytes are captured by a monitor queue and compared against a model.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     at;
  } rec_t;

  typedef struct {
    logic [7:0] din;
    logic       par;
    logic       stp;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  rec_t got[$];

  uart_rx #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_tick    (rx_tick),
    .rx         (rx),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial forever #5 clock = ~clock;

  // rx_tick: one clock high out of every four, changed on the falling edge
  initial forever begin
    repeat (3) begin
      @(negedge clock);
      rx_tick = 1'b0;
    end
    @(negedge clock);
    rx_tick = 1'b1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every rx_done pulse with the outputs valid alongside it
  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
      rec_t r;
      r.d = data_out;
      r.pe = parity_err;
      r.fe = frame_err;
      r.at = cyc;
      got.push_back(r);
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      while (rx_tick !== 1'b1) @(posedge clock);
    end
    #1;
  endtask

  // Drive one frame: start 0, data LSB first, parity bit, stop bit, then idle high
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int idle);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      wait_ticks(16);
    end
    rx = 1'b1;
    if (idle > 0) wait_ticks(idle);
  endtask

  // Reference: even parity means the count of ones over data+parity is even
  function automatic rec_t model(input logic [7:0] d, input logic p, input logic s);
    rec_t m;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(p);
    m.d = d;
    m.pe = (ones % 2) != 0;
    m.fe = (s == 1'b0);
    m.at = 0;
    return m;
  endfunction

  task automatic expect_frame(input string nm, input rec_t m, input int n_before);
    rec_t r;
    check({nm, " pulses"}, 32'(got.size()), 32'(n_before + 1));
    if (got.size() > n_before) begin
      r = got[n_before];
      check({nm, " data"}, 32'(r.d), 32'(m.d));
      check({nm, " parity_err"}, 32'(r.pe), 32'(m.pe));
      check({nm, " frame_err"}, 32'(r.fe), 32'(m.fe));
    end
  endtask

  initial begin
    vec_t tbl[4];
    rec_t m;
    int n0;
    int busy_cnt;
    logic [7:0] d;
    logic bp, bs;
    int idle;
    logic [7:0] held_d;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset rx_done", 32'(rx_done), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset rx_busy", 32'(rx_busy), 32'h0);
    reset_n = 1'b1;
    wait_ticks(20);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      n0 = got.size();
      send_frame(tbl[i].din, tbl[i].par, tbl[i].stp, 8);
      m.d = tbl[i].exp_d;
      m.pe = tbl[i].exp_pe;
      m.fe = tbl[i].exp_fe;
      expect_frame($sformatf("vec%0d", i), m, n0);
      check($sformatf("vec%0d busy after", i), 32'(rx_busy), 32'h0);
      check($sformatf("vec%0d held data_out", i), 32'(data_out), 32'(tbl[i].exp_d));
    end

    // Start glitch: 4 ticks low must not start a frame; busy for 8 ticks
    n0 = got.size();
    held_d = data_out;
    busy_cnt = 0;
    fork
      begin
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
      end
      begin
        repeat (96) begin
          @(negedge clock);
          if (rx_busy === 1'b1) busy_cnt++;
        end
      end
    join
    check("glitch busy clocks", 32'(busy_cnt), 32'd32);
    check("glitch no pulse", 32'(got.size()), 32'(n0));
    check("glitch data held", 32'(data_out), 32'(held_d));
    check("glitch frame_err held", 32'(frame_err), 32'h0);

    // Back-to-back frames with no idle gap
    n0 = got.size();
    send_frame(8'h55, 1'b0, 1'b1, 0);
    send_frame(8'hAA, 1'b0, 1'b1, 8);
    check("b2b pulses", 32'(got.size()), 32'(n0 + 2));
    if (got.size() >= n0 + 2) begin
      check("b2b data0", 32'(got[n0].d), 32'h55);
      check("b2b data1", 32'(got[n0+1].d), 32'hAA);
      check("b2b errs", 32'({got[n0].pe, got[n0].fe, got[n0+1].pe, got[n0+1].fe}), 32'h0);
      check("b2b spacing", 32'(got[n0+1].at - got[n0].at), 32'd704);
    end

    // Reset in the middle of the data bits of 0x0F
    n0 = got.size();
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    wait_ticks(8);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset busy", 32'(rx_busy), 32'h0);
    check("midreset outputs", 32'({data_out, parity_err, frame_err, rx_done}), 32'h0);
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    wait_ticks(20);
    check("midreset no pulse", 32'(got.size()), 32'(n0));
    send_frame(8'h0F, 1'b0, 1'b1, 8);
    expect_frame("after reset", model(8'h0F, 1'b0, 1'b1), n0);

    // Break: line held low produces a zero byte with a framing error,
    // then the receiver stays idle until the line returns high
    n0 = got.size();
    rx = 1'b0;
    wait_ticks(200);
    m.d = 8'h00;
    m.pe = 1'b0;
    m.fe = 1'b1;
    expect_frame("break", m, n0);
    busy_cnt = 0;
    repeat (160) begin
      @(negedge clock);
      if (rx_busy === 1'b1) busy_cnt++;
    end
    check("break idle busy", 32'(busy_cnt), 32'h0);
    check("break single pulse", 32'(got.size()), 32'(n0 + 1));
    rx = 1'b1;
    wait_ticks(16);
    n0 = got.size();
    send_frame(8'h5A, 1'b0, 1'b1, 8);
    expect_frame("after break", model(8'h5A, 1'b0, 1'b1), n0);

    // Random frames with occasional parity or stop-bit corruption
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      bp = (^d) ^ ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) != 0);
      idle = bs ? $urandom_range(0, 12) : $urandom_range(2, 12);
      n0 = got.size();
      send_frame(d, bp, bs, idle);
      expect_frame($sformatf("rand%0d", k), model(d, bp, bs), n0);
    end

    wait_ticks(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the frame format our transmitter produces.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit equal to the XOR of the data bits (even parity), 1 stop bit (1).
- Samples the serial line with an oversampling tick and reports each received byte with a one-cycle done pulse plus parity and framing error flags.
- Sits between the pad-side serial input and the byte-level consumer, mirroring the transmitter on the link.

Parameters:
OVERSAMPLE, 16, rx_tick pulses per bit period; must be even and >= 4.
SYNC_STAGES, 2, number of flops in the rx input synchronizer; must be >= 2.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous active-low reset; the only reset.
rx_tick  input  1  one-cycle enable pulse at OVERSAMPLE x baud rate.
rx  input  1  serial line, asynchronous to clock; idle level is 1.
data_out  output  8  last received byte; held until the next frame completes.
rx_done  output  1  one-cycle pulse; data_out, parity_err and frame_err are valid in the same cycle.
parity_err  output  1  1 when the last frame failed the parity check; held.
frame_err  output  1  1 when the last frame's stop bit sampled 0; held.
rx_busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - Synchronizer flops reset to 1.
  - Tick counter, bit counter and shift register reset to 0.
  - data_out = 0, rx_done = 0, parity_err = 0, frame_err = 0, rx_busy = 0.
- rx passes through SYNC_STAGES flops; the FSM uses only the synchronized value rx_s.
- All counters and state advance only in cycles where rx_tick = 1; with rx_tick = 0 everything holds and rx_done = 0.
- Counters: tick_cnt is log2(OVERSAMPLE) bits; bit_cnt is 4 bits; shreg is 9 bits.
- IDLE:
  - On rx_tick with rx_s = 0: go to START, tick_cnt = 0.
- START:
  - Each rx_tick increments tick_cnt.
  - When tick_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rx_s = 0: go to DATA, tick_cnt = 0, bit_cnt = 0.
    - rx_s = 1: glitch; return to IDLE with no outputs changed.
- DATA:
  - Each rx_tick increments tick_cnt.
  - When tick_cnt = OVERSAMPLE-1 (mid bit), all in the same update:
    - shreg = {rx_s, shreg[8:1]}.
    - tick_cnt = 0, bit_cnt increments.
  - After the 9th sample (bit_cnt was 8): go to STOP.
  - Result: shreg[7:0] holds the data and shreg[8] the parity bit.
- STOP:
  - When tick_cnt = OVERSAMPLE-1 (mid stop bit), all on one clock edge:
    - data_out = shreg[7:0].
    - parity_err = ^shreg (XOR of 9 bits).
    - frame_err = ~rx_s.
    - rx_done = 1 for exactly one cycle.
    - Go to IDLE.
  - Returning at mid stop bit lets the next start edge be caught even with zero idle time between frames.
- Output timing:
  - Outputs are registered and update on the edge where the mid-stop rx_tick is sampled.
  - Latency from the stop bit's centre to rx_done is 1 clock.
- Error frames:
  - A frame with a parity or framing error still updates data_out.
  - A break (rx held at 0) yields data_out = 0x00, parity_err = 0, frame_err = 1, then the FSM waits in IDLE for rx_s = 1 before a new start bit can begin.
- Each frame overwrites the error flags; they are not sticky across frames.
- No flow control: the consumer must capture data_out on rx_done before the next frame completes, otherwise the byte is overwritten.
- Reset mid-frame: the frame is aborted immediately, no rx_done is produced, and the next falling edge after release starts a fresh frame.

Decomposition:
- Shared package uart_pkg, used by both transmitter and receiver:
  - 2-bit state encodings IDLE = 00, START = 01, DATA = 10, STOP = 11.
  - DATA_BITS = 8.
  - FRAME_BITS = 9 (data + parity).
  - A parity function (XOR reduce).
- One sub-module: uart_rx_sync, a parameterised SYNC_STAGES-deep bit synchronizer with reset value 1.

Test Plan:
Common setup: OVERSAMPLE = 16, rx_tick every 4 clocks, bits driven 16 ticks wide.
1. Valid frame 0xA5 with parity 0 -> one rx_done pulse, data_out = 0xA5, parity_err = 0, frame_err = 0, rx_busy low after the pulse.
2. 0x01 sent with parity bit 0 (correct value 1) -> rx_done, data_out = 0x01, parity_err = 1, frame_err = 0.
3. 0x3C with correct parity but stop bit 0 -> rx_done, data_out = 0x3C, frame_err = 1, parity_err = 0; a following good 0x3C frame clears frame_err.
4. rx low for 4 ticks, then high -> no rx_done; rx_busy high for 8 ticks, then 0; outputs unchanged.
5. Back-to-back frames 0x55 then 0xAA with no idle gap -> two rx_done pulses 11 bit periods apart, data_out 0x55 then 0xAA, no errors.
6. reset_n pulsed low mid-DATA of 0x0F -> rx_busy = 0 and all outputs 0 immediately, no rx_done; the next full 0x0F frame is received correctly.
